// File: rtl/main_memory_responder.sv
// Word-addressed RAM with a small MMIO window: status, output FIFO, optional cycle counter.
// Define CYCLE_COUNTER_EN to include the 32-bit cycle counter and its coherent-read shadow.
module main_memory_responder #(
  parameter int unsigned MEM_DEPTH_LOG2  = 10,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address_from_core,
  input  logic [15:0] data_from_core,
  input  logic        data_from_core_write_en,
  output logic [15:0] data_to_core,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready
);

  localparam int unsigned MEM_DEPTH  = 1 << MEM_DEPTH_LOG2;
  localparam int unsigned FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W      = FIFO_DEPTH_LOG2 + 1;

  localparam logic [15:0] ADDR_STATUS   = 16'hFF00;
  localparam logic [15:0] ADDR_OUT_DATA = 16'hFF01;
  localparam logic [15:0] ADDR_CYC_LO   = 16'hFF02;
  localparam logic [15:0] ADDR_CYC_HI   = 16'hFF03;

  localparam logic [CNT_W-1:0]           CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]           CNT_ONE  = CNT_W'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);

  logic [15:0] ram_q  [MEM_DEPTH];
  logic [15:0] fifo_q [FIFO_DEPTH];

  logic [15:0]                data_to_core_q, data_to_core_d;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       overflow_q, overflow_d;

  logic                      is_mmio;
  logic [MEM_DEPTH_LOG2-1:0] ram_idx;
  logic                      ram_we;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push_req;
  logic                      pop_req;
  logic                      push_ok;
  logic [15:0]               count_wide;
  logic [15:0]               status_word;

  assign is_mmio    = (address_from_core[15:8] == 8'hFF);
  assign ram_idx    = address_from_core[MEM_DEPTH_LOG2-1:0];
  assign ram_we     = data_from_core_write_en && !is_mmio && !reset;
  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign push_req   = data_from_core_write_en && (address_from_core == ADDR_OUT_DATA) && !reset;
  assign pop_req    = !fifo_empty && out_ready && !reset;
  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign push_ok    = push_req && (!fifo_full || pop_req);

  assign count_wide  = 16'(count_q);
  assign status_word = {count_wide[7:0], 5'b0, overflow_q, fifo_full, fifo_empty};

  assign data_to_core = data_to_core_q;
  assign out_valid    = !fifo_empty;
  assign out_data     = fifo_q[rd_ptr_q];

`ifdef CYCLE_COUNTER_EN
  logic [31:0] cycle_q, cycle_d;
  logic [15:0] shadow_q, shadow_d;

  always_comb begin
    cycle_d  = cycle_q + 32'd1;
    shadow_d = shadow_q;
    // Capturing the upper half on the LO read keeps a LO-then-HI pair coherent.
    if (address_from_core == ADDR_CYC_LO && !data_from_core_write_en) begin
      shadow_d = cycle_q[31:16];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q  <= '0;
      shadow_q <= '0;
    end else begin
      cycle_q  <= cycle_d;
      shadow_q <= shadow_d;
    end
  end
`endif

  always_comb begin
    data_to_core_d = '0;
    if (!is_mmio) begin
      data_to_core_d = data_from_core_write_en ? data_from_core : ram_q[ram_idx];
    end else begin
      case (address_from_core)
        ADDR_STATUS: data_to_core_d = status_word;
`ifdef CYCLE_COUNTER_EN
        ADDR_CYC_LO: data_to_core_d = cycle_q[15:0];
        ADDR_CYC_HI: data_to_core_d = shadow_q;
`endif
        default:     data_to_core_d = '0;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_req) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_req})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (push_req && fifo_full && !pop_req) begin
      overflow_d = 1'b1;
    end else if (data_from_core_write_en && address_from_core == ADDR_STATUS) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_to_core_q <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
    end else begin
      data_to_core_q <= data_to_core_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= data_from_core;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= data_from_core;
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: RAM latency/aliasing, MMIO status, FIFO, counter.
module tb_main_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address_from_core;
  logic [15:0] data_from_core;
  logic        data_from_core_write_en;
  logic [15:0] data_to_core;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  main_memory_responder #(
    .MEM_DEPTH_LOG2 (10),
    .FIFO_DEPTH_LOG2(3)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .address_from_core      (address_from_core),
    .data_from_core         (data_from_core),
    .data_from_core_write_en(data_from_core_write_en),
    .data_to_core           (data_to_core),
    .out_valid              (out_valid),
    .out_data               (out_data),
    .out_ready              (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] addr, input logic [15:0] data,
                       input logic we, input logic rdy);
    address_from_core       = addr;
    data_from_core          = data;
    data_from_core_write_en = we;
    out_ready               = rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_dout", data_to_core, 16'h0000);
    check("rst_valid", {15'b0, out_valid}, 16'h0000);
    reset = 1'b0;

    drive(16'hFF00, 16'h0000, 1'b0, 1'b0); tick();
    check("status_after_rst", data_to_core, 16'h0001);

    drive(16'h0010, 16'h1234, 1'b1, 1'b0); tick();
    check("write_first", data_to_core, 16'h1234);
    drive(16'h0010, 16'h0000, 1'b0, 1'b0); tick();
    check("rd_0010", data_to_core, 16'h1234);

    drive(16'h0405, 16'hBEEF, 1'b1, 1'b0); tick();
    drive(16'h0005, 16'h0000, 1'b0, 1'b0); tick();
    check("alias_0005", data_to_core, 16'hBEEF);

    drive(16'h0304, 16'hA5A5, 1'b1, 1'b0); tick();
    drive(16'hFF04, 16'h5555, 1'b1, 1'b0); tick();
    check("mmio_ff04_rd", data_to_core, 16'h0000);
    drive(16'h0304, 16'h0000, 1'b0, 1'b0); tick();
    check("ram_not_hit_by_mmio", data_to_core, 16'hA5A5);

    for (int i = 0; i < 9; i++) begin
      drive(16'hFF01, 16'h0100 + 16'(i), 1'b1, 1'b0); tick();
    end
    check("fill_valid", {15'b0, out_valid}, 16'h0001);
    check("fill_head", out_data, 16'h0100);
    drive(16'hFF00, 16'h0000, 1'b0, 1'b0); tick();
    check("status_overflow", data_to_core, 16'h0806);
    drive(16'hFF00, 16'h0000, 1'b1, 1'b0); tick();
    drive(16'hFF00, 16'h0000, 1'b0, 1'b0); tick();
    check("status_ovf_cleared", data_to_core, 16'h0802);
    drive(16'hFF01, 16'h0000, 1'b0, 1'b0); tick();
    check("rd_out_data_reg", data_to_core, 16'h0000);

    drive(16'hFF01, 16'h0200, 1'b1, 1'b1); tick();
    check("full_pushpop_head", out_data, 16'h0101);
    drive(16'hFF00, 16'h0000, 1'b0, 1'b0); tick();
    check("full_pushpop_status", data_to_core, 16'h0802);

    drive(16'h0010, 16'h0000, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("drain_order", out_data, 16'h0101 + 16'(k));
      tick();
    end
    drive(16'hFF00, 16'h0000, 1'b0, 1'b0); tick();
    check("status_three", data_to_core, 16'h0300);
    check("head_after_drain", out_data, 16'h0106);

    reset = 1'b1;
    drive(16'hFF01, 16'h7777, 1'b1, 1'b1); tick();
    reset = 1'b0;
    check("flush_valid", {15'b0, out_valid}, 16'h0000);
    drive(16'hFF00, 16'h0000, 1'b0, 1'b0); tick();
    check("flush_status", data_to_core, 16'h0001);
    drive(16'h0010, 16'h0000, 1'b0, 1'b0); tick();
    check("ram_kept_over_reset", data_to_core, 16'h1234);

    drive(16'hFF01, 16'h4242, 1'b1, 1'b1); tick();
    check("empty_pushpop_valid", {15'b0, out_valid}, 16'h0001);
    check("empty_pushpop_head", out_data, 16'h4242);
    drive(16'hFF00, 16'h0000, 1'b0, 1'b0); tick();
    check("empty_pushpop_status", data_to_core, 16'h0100);

`ifdef CYCLE_COUNTER_EN
    drive(16'hFF02, 16'h0000, 1'b0, 1'b0);
    force dut.cycle_q = 32'h0001FFFF;
    #1;
    release dut.cycle_q;
    tick();
    check("cycle_lo", data_to_core, 16'hFFFF);
    drive(16'hFF03, 16'h0000, 1'b0, 1'b0); tick();
    check("cycle_hi_shadow", data_to_core, 16'h0001);
`else
    drive(16'hFF02, 16'h0000, 1'b0, 1'b0); tick();
    check("cycle_lo_absent", data_to_core, 16'h0000);
    drive(16'hFF03, 16'h0000, 1'b0, 1'b0); tick();
    check("cycle_hi_absent", data_to_core, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
